// File: rtl/player_grid_ctrl.sv
// rtl/player_grid_ctrl.sv - player token controller: edge-detected moves, goal scoring, lives, respawn
// Owns the token position and game state and feeds a registered per-tile draw flag to the pixel mux.
module player_grid_ctrl #(
  parameter int GRID_W         = 20,
  parameter int GRID_H         = 15,
  parameter int COORD_W        = 6,
  parameter int START_X        = 10,
  parameter int START_Y        = 14,
  parameter int GOAL_Y         = 0,
  parameter int SCORE_W        = 7,
  parameter int LIVES          = 3,
  parameter int RESPAWN_CYCLES = 25000000
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_Game_Active,
  input  logic               i_Up,
  input  logic               i_Down,
  input  logic               i_Left,
  input  logic               i_Right,
  input  logic               i_Collided,
  input  logic [COORD_W-1:0] i_Col_Count_Div,
  input  logic [COORD_W-1:0] i_Row_Count_Div,
  output logic               o_Draw_Player,
  output logic [COORD_W-1:0] o_Player_X,
  output logic [COORD_W-1:0] o_Player_Y,
  output logic [SCORE_W-1:0] o_Score,
  output logic [2:0]         o_Lives,
  output logic               o_Goal_Pulse,
  output logic               o_Game_Over
);

  localparam int CNT_W = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;

  localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] SPAWN_X  = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] SPAWN_Y  = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] GOAL_ROW = COORD_W'(GOAL_Y);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(RESPAWN_CYCLES - 1);
  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DYING = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [3:0]         sw_q;
  logic [3:0]         sw_now;
  logic [3:0]         press;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         lives_q, lives_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               goal_q, goal_d;
  logic               draw_q;

  logic [COORD_W-1:0] mv_x, mv_y;
  logic               mv_valid;
  logic               goal_hit;
  logic               terminal;

  assign sw_now   = {i_Up, i_Down, i_Left, i_Right};
  assign press    = sw_now & ~sw_q;
  assign terminal = (cnt_q == CNT_LAST);

  // Only the highest-priority press is considered; if it hits a wall nothing moves.
  always_comb begin
    mv_x     = x_q;
    mv_y     = y_q;
    mv_valid = 1'b0;
    if (press[3]) begin
      if (y_q != '0) begin
        mv_y     = y_q - COORD_W'(1);
        mv_valid = 1'b1;
      end
    end else if (press[2]) begin
      if (y_q != Y_MAX) begin
        mv_y     = y_q + COORD_W'(1);
        mv_valid = 1'b1;
      end
    end else if (press[1]) begin
      if (x_q != '0) begin
        mv_x     = x_q - COORD_W'(1);
        mv_valid = 1'b1;
      end
    end else if (press[0]) begin
      if (x_q != X_MAX) begin
        mv_x     = x_q + COORD_W'(1);
        mv_valid = 1'b1;
      end
    end
  end

  assign goal_hit = mv_valid && (mv_y == GOAL_ROW);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_Game_Active) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (!i_Game_Active)  state_d = S_IDLE;
        else if (i_Collided) state_d = S_DYING;
      end
      S_DYING: begin
        if (!i_Game_Active) state_d = S_IDLE;
        else if (terminal)  state_d = (lives_q == 3'd0) ? S_OVER : S_PLAY;
      end
      S_OVER: begin
        if (!i_Game_Active) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Collision is tested before the move so a same-cycle goal never scores.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    score_d = score_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    goal_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        x_d = SPAWN_X;
        y_d = SPAWN_Y;
        if (i_Game_Active) begin
          score_d = '0;
          lives_d = LIVES_INIT;
        end
      end
      S_PLAY: begin
        if (!i_Game_Active) begin
          x_d = SPAWN_X;
          y_d = SPAWN_Y;
        end else if (i_Collided) begin
          if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
          cnt_d = '0;
        end else if (goal_hit) begin
          goal_d = 1'b1;
          x_d    = SPAWN_X;
          y_d    = SPAWN_Y;
          if (score_q != '1) score_d = score_q + SCORE_W'(1);
        end else if (mv_valid) begin
          x_d = mv_x;
          y_d = mv_y;
        end
      end
      S_DYING: begin
        if (!i_Game_Active) begin
          x_d = SPAWN_X;
          y_d = SPAWN_Y;
        end else if (terminal) begin
          if (lives_q != 3'd0) begin
            x_d = SPAWN_X;
            y_d = SPAWN_Y;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_OVER: begin
        if (!i_Game_Active) begin
          x_d = SPAWN_X;
          y_d = SPAWN_Y;
        end
      end
      default: begin
        x_d = SPAWN_X;
        y_d = SPAWN_Y;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sw_q    <= '0;
      x_q     <= SPAWN_X;
      y_q     <= SPAWN_Y;
      score_q <= '0;
      lives_q <= LIVES_INIT;
      cnt_q   <= '0;
      goal_q  <= 1'b0;
      draw_q  <= 1'b0;
    end else begin
      sw_q    <= sw_now;
      x_q     <= x_d;
      y_q     <= y_d;
      score_q <= score_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      goal_q  <= goal_d;
      draw_q  <= (i_Col_Count_Div == x_q) && (i_Row_Count_Div == y_q) && (state_q != S_DYING);
    end
  end

  assign o_Draw_Player = draw_q;
  assign o_Player_X    = x_q;
  assign o_Player_Y    = y_q;
  assign o_Score       = score_q;
  assign o_Lives       = lives_q;
  assign o_Goal_Pulse  = goal_q;
  assign o_Game_Over   = (state_q == S_OVER);

endmodule

// File: doc/player_grid_ctrl.md
Name: player_grid_ctrl

Overview:
- Parametrised successor to the single-instance frog controller.
- Tracks one player token on a GRID_W x GRID_H tile grid:
  - edge-detected direction inputs with fixed priority
  - goal detection with saturating score
  - collision handling with a lives counter and timed respawn
  - game-over latch
  - registered per-tile draw flag for the VGA tile pipeline
- Sits between the switch debouncers / collision detector and the pixel mux.

Parameters:
- GRID_W, 20, grid columns; X range 0..GRID_W-1.
- GRID_H, 15, grid rows; Y range 0..GRID_H-1.
- COORD_W, 6, width of X/Y and tile-count ports.
- START_X, 10, spawn column.
- START_Y, 14, spawn row.
- GOAL_Y, 0, row that scores when entered.
- SCORE_W, 7, score width.
- LIVES, 3, lives at game start; 1..7.
- RESPAWN_CYCLES, 25000000, clocks spent in DYING before respawn; must be >= 1.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_Game_Active  in  1  level; game running.
- i_Up  in  1  debounced switch; a press moves Y-1.
- i_Down  in  1  debounced switch; a press moves Y+1.
- i_Left  in  1  debounced switch; a press moves X-1.
- i_Right  in  1  debounced switch; a press moves X+1.
- i_Collided  in  1  level; player overlaps a hazard.
- i_Col_Count_Div  in  COORD_W  current tile column being scanned.
- i_Row_Count_Div  in  COORD_W  current tile row being scanned.
- o_Draw_Player  out  1  player occupies scanned tile; 1-cycle latency.
- o_Player_X  out  COORD_W  current column.
- o_Player_Y  out  COORD_W  current row.
- o_Score  out  SCORE_W  goals reached this game.
- o_Lives  out  3  remaining lives.
- o_Goal_Pulse  out  1  one-cycle strobe when the goal is reached.
- o_Game_Over  out  1  high in GAME_OVER state.

Behaviour:

Reset (i_Rst_L low, asynchronous):
- state = IDLE.
- X = START_X, Y = START_Y.
- score = 0, lives = LIVES.
- All strobes and flags = 0.
- Switch history registers = 0.

Edge detection:
- Each switch is registered every cycle. press = input & ~registered_previous.
- Held switches produce exactly one move.
- Priority: Up > Down > Left > Right. At most one move per cycle; lower-priority presses in the same cycle are discarded, not queued.

Bounds:
- A move that would leave 0..GRID_W-1 or 0..GRID_H-1 is ignored. Position is unchanged; no wrap-around.

State machine:
- IDLE:
  - Position held at spawn; presses ignored.
  - On i_Game_Active = 1: score = 0, lives = LIVES, spawn position, go to PLAY.
- PLAY:
  - Apply at most one move per cycle.
  - If i_Collided = 1: lives -= 1, position frozen, counter cleared, go to DYING. The move in the same cycle is discarded. Collision beats goal.
  - Else if the move lands on Y == GOAL_Y:
    - o_Goal_Pulse = 1 for one cycle.
    - score += 1, saturating at 2^SCORE_W-1.
    - Position set to spawn in the same update; X/Y never present GOAL_Y for a full cycle.
- DYING:
  - Presses and i_Collided ignored; o_Draw_Player forced 0.
  - Counter runs 0..RESPAWN_CYCLES-1.
  - On terminal count:
    - lives == 0: go to GAME_OVER.
    - otherwise: spawn position, go to PLAY.
- GAME_OVER:
  - o_Game_Over = 1; position and score held.
  - On i_Game_Active = 0: go to IDLE.

Game abort:
- i_Game_Active = 0 in PLAY or DYING: go to IDLE next cycle.
- Position returns to spawn; score and lives hold their last values until the next start.

Lives:
- Never decrement below 0.
- Mid-game reset restores all reset values immediately.

Draw flag:
- o_Draw_Player registered = (col == X) && (row == Y) && state != DYING, evaluated on the prior cycle's values.

Test Plan:
- Reset, i_Game_Active = 1, hold i_Right high 10 cycles -> X = 11 after exactly one move, Y = 14, state PLAY.
- From X = 19, pulse i_Right; from Y = 14, pulse i_Down -> X stays 19, Y stays 14.
- Pulse i_Up and i_Left in the same cycle at (10,14) -> (10,13); Left is dropped.
- 14 Up presses from spawn -> o_Goal_Pulse high exactly 1 cycle, o_Score = 1, position (10,14). With score preset to 127 -> score stays 127.
- RESPAWN_CYCLES = 4, assert i_Collided with a simultaneous goal-reaching Up -> lives 3 -> 2, no goal pulse, o_Draw_Player = 0 for 4 cycles, then PLAY at (10,14).
- Three collisions -> o_Lives = 0 and o_Game_Over = 1 after the final DYING. Drop i_Game_Active -> IDLE. Raise it again -> score 0, lives 3. Assert i_Rst_L low mid-DYING -> immediate IDLE with reset values.
